// File: rtl/sdp_pipe_impl_if.sv
// sdp_pipe_impl_if
//   Operand/result handshake bundle for the sdp pipeline.
//   master : drives operands and out_ready, observes in_ready and the result
//   slave  : the pipeline itself
// Signals
//   in_valid / in_ready    : operand bundle handshake
//   ctl_1, ctl_2, a, b, c  : operand bundle (a, b, c are WIDTH bits)
//   out_valid / out_ready  : result handshake
//   out_data               : WIDTH-bit result
interface sdp_pipe_impl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             ctl_1;
    logic             ctl_2;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, ctl_1, ctl_2, a, b, c, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, ctl_1, ctl_2, a, b, c, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sdp_pipe_impl.sv
// sdp_pipe_impl
//   Three-stage elastic pipeline computing
//     t = ctl_1 ? a + b : a - b          (modulo 2^WIDTH)
//     r = ctl_2 ? t ^ c : t + c          (modulo 2^WIDTH)
//   A result is visible after the third clock edge counting the accepting edge,
//   with one result per cycle while out_ready stays high.
// Ports
//   clk      : clock, all state on posedge
//   reset_n  : asynchronous active-low reset
//   flush    : synchronous kill of every in-flight entry; blocks acceptance
//   bus      : sdp_pipe_impl_if.slave (operand and result handshakes)
//   done_cnt : CNT_W-bit count of consumed results, wraps
module sdp_pipe_impl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    sdp_pipe_impl_if.slave   bus,
    output logic [CNT_W-1:0] done_cnt
);

    function automatic logic [WIDTH-1:0] calc_t(input logic             sel_add,
                                               input logic [WIDTH-1:0] op_a,
                                               input logic [WIDTH-1:0] op_b);
        return sel_add ? (op_a + op_b) : (op_a - op_b);
    endfunction

    function automatic logic [WIDTH-1:0] calc_r(input logic             sel_xor,
                                               input logic [WIDTH-1:0] op_t,
                                               input logic [WIDTH-1:0] op_c);
        return sel_xor ? (op_t ^ op_c) : (op_t + op_c);
    endfunction

    logic             vld_p0, vld_p1, vld_p2;
    logic [WIDTH-1:0] t_p0, c_p0;
    logic             ctl_2_p0;
    logic [WIDTH-1:0] r_p1;
    logic [WIDTH-1:0] data_p2;

    logic adv_p0, adv_p1, adv_p2;
    logic accept;
    logic consume;

    // A stage may take new content when it is empty or its successor moves.
    assign adv_p2  = !vld_p2 | bus.out_ready;
    assign adv_p1  = !vld_p1 | adv_p2;
    assign adv_p0  = !vld_p0 | adv_p1;

    assign bus.in_ready  = adv_p0 & !flush;
    assign accept        = bus.in_valid & bus.in_ready;
    assign consume       = vld_p2 & bus.out_ready;

    assign bus.out_valid = vld_p2;
    assign bus.out_data  = data_p2;

    // Valid bits and the consumed-result counter. Flush overrides every
    // handshake, including a result being consumed in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            done_cnt <= '0;
        end else if (flush) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            if (adv_p0) vld_p0 <= accept;
            if (adv_p1) vld_p1 <= vld_p0;
            if (adv_p2) vld_p2 <= vld_p1;
            if (consume) done_cnt <= done_cnt + CNT_W'(1);
        end
    end

    // Data registers load only with a real entry, so bubbles keep the old
    // value and ctl inputs are never sampled while in_valid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_p0     <= '0;
            c_p0     <= '0;
            ctl_2_p0 <= 1'b0;
            r_p1     <= '0;
            data_p2  <= '0;
        end else begin
            // stage p0: first operation and operand capture
            if (accept) begin
                t_p0     <= calc_t(bus.ctl_1, bus.a, bus.b);
                c_p0     <= bus.c;
                ctl_2_p0 <= bus.ctl_2;
            end
            // stage p1: second operation
            if (adv_p1 && vld_p0 && !flush)
                r_p1 <= calc_r(ctl_2_p0, t_p0, c_p0);
            // stage p2: output register
            if (adv_p2 && vld_p1 && !flush)
                data_p2 <= r_p1;
        end
    end

endmodule

// File: tb/tb_sdp_pipe_impl.sv
module tb_sdp_pipe_impl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic [CW-1:0] done_cnt;

    int checks   = 0;
    int failures = 0;

    sdp_pipe_impl_if #(.WIDTH(W)) bus ();

    sdp_pipe_impl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .bus      (bus.slave),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference function written directly from the arithmetic rules.
    function automatic logic [7:0] golden(input bit c1, input bit c2,
                                          input int a, input int b, input int c);
        int t;
        int r;
        t = c1 ? (a + b) % 256 : (a - b + 256) % 256;
        r = c2 ? (t ^ c) : (t + c) % 256;
        return 8'(r);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit c1, input bit c2,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.in_valid = v;
        bus.ctl_1    = c1;
        bus.ctl_2    = c2;
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        flush   = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        flush   = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
        checks++;
        if (done_cnt !== 4'd0) begin failures++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_arith;
        bit         c1v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bit         c2v [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] av  [4] = '{8'd200, 8'd5,  8'd255, 8'd0};
        logic [7:0] bv  [4] = '{8'd100, 8'd10, 8'd1,   8'd1};
        logic [7:0] cv  [4] = '{8'd6,   8'hFF, 8'd255, 8'd2};
        logic [7:0] ev  [4] = '{8'd50,  8'h04, 8'd255, 8'd1};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            drive(1'b1, c1v[i], c2v[i], av[i], bv[i], cv[i]);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL arith%0d_in_ready got=%0b exp=1", i, bus.in_ready); end
            tick();
            idle();
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arith%0d_early_valid got=%0b exp=0", i, bus.out_valid); end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL arith%0d_valid got=%0b exp=1", i, bus.out_valid); end
            checks++;
            if (bus.out_data !== ev[i]) begin failures++; $display("FAIL arith%0d_data got=%0d exp=%0d", i, bus.out_data, ev[i]); end
            tick();
            checks++;
            if (done_cnt !== 4'd1) begin failures++; $display("FAIL arith%0d_done_cnt got=%0d exp=1", i, done_cnt); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] q[$];
        logic [7:0] ia[6], ib[6], ic[6];
        bit         i1[6], i2[6];
        int acc = 0;
        int outs = 0;
        for (int i = 0; i < 6; i++) begin
            ia[i] = 8'($urandom); ib[i] = 8'($urandom); ic[i] = 8'($urandom);
            i1[i] = 1'($urandom); i2[i] = 1'($urandom);
        end
        do_reset();
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(1'b1, i1[acc], i2[acc], ia[acc], ib[acc], ic[acc]);
            #1;
            if (bus.in_ready) begin
                q.push_back(golden(i1[acc], i2[acc], ia[acc], ib[acc], ic[acc]));
                acc++;
            end
            tick();
        end
        #1;
        checks++;
        if (acc !== 3) begin failures++; $display("FAIL bp_accepts got=%0d exp=3", acc); end
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", bus.in_ready); end
        for (int h = 0; h < 3; h++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== q[0]) begin
                failures++;
                $display("FAIL bp_hold%0d got=%0b/%0d exp=1/%0d", h, bus.out_valid, bus.out_data, q[0]);
            end
            tick();
            #1;
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && outs < 6; cyc++) begin
            if (acc < 6) drive(1'b1, i1[acc], i2[acc], ia[acc], ib[acc], ic[acc]);
            else idle();
            #1;
            if (bus.out_valid) begin
                checks++;
                if (q.size() == 0 || bus.out_data !== q[0]) begin
                    failures++;
                    $display("FAIL bp_order%0d got=%0d exp=%0d", outs, bus.out_data, (q.size() != 0) ? q[0] : 8'd0);
                end
                if (q.size() != 0) void'(q.pop_front());
                outs++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(golden(i1[acc], i2[acc], ia[acc], ib[acc], ic[acc]));
                acc++;
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (outs !== 6) begin failures++; $display("FAIL bp_result_count got=%0d exp=6", outs); end
        checks++;
        if (done_cnt !== 4'd6) begin failures++; $display("FAIL bp_done_cnt got=%0d exp=6", done_cnt); end
    endtask

    task automatic test_flush;
        logic [7:0] e;
        // two entries in flight, flush with a valid input present
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 8'd1, 8'd2, 8'd3);
        flush = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b exp=0", bus.in_ready); end
        tick();
        flush = 1'b0;
        idle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak%0d got=%0b exp=0", i, bus.out_valid); end
            tick();
        end
        checks++;
        if (done_cnt !== 4'd0) begin failures++; $display("FAIL flush_done_cnt got=%0d exp=0", done_cnt); end
        e = golden(1'b0, 1'b1, 9, 4, 8'h0F);
        drive(1'b1, 1'b0, 1'b1, 8'd9, 8'd4, 8'h0F);
        tick();
        idle();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_relat_early got=%0b exp=0", bus.out_valid); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
            failures++;
            $display("FAIL flush_relat got=%0b/%0d exp=1/%0d", bus.out_valid, bus.out_data, e);
        end
        // full pipeline, flush in the same cycle a result is consumed
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        idle();
        flush = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%0b exp=1", bus.out_valid); end
        tick();
        flush = 1'b0;
        checks++;
        if (done_cnt !== 4'd0) begin failures++; $display("FAIL flush_consume_cnt got=%0d exp=0", done_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_leak%0d got=%0b exp=0", i, bus.out_valid); end
            tick();
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        idle();
        checks++;
        if (done_cnt !== 4'd2 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got=%0d/%0b exp=2/1", done_cnt, bus.out_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", bus.out_valid); end
        checks++;
        if (done_cnt !== 4'd0) begin failures++; $display("FAIL midrst_done_cnt got=%0d exp=0", done_cnt); end
        checks++;
        if (bus.out_data !== 8'd0) begin failures++; $display("FAIL midrst_data got=%0d exp=0", bus.out_data); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        e = golden(1'b1, 1'b1, 10, 20, 3);
        drive(1'b1, 1'b1, 1'b1, 8'd10, 8'd20, 8'd3);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%0b exp=1", bus.in_ready); end
        tick();
        idle();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_early got=%0b exp=0", bus.out_valid); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
            failures++;
            $display("FAIL midrst_first got=%0b/%0d exp=1/%0d", bus.out_valid, bus.out_data, e);
        end
    endtask

    task automatic test_random;
        localparam int N = 60;
        bit         vexp [0:N+7];
        logic [7:0] dexp [0:N+7];
        int  exp_cnt = 0;
        int  n_in  = 0;
        int  n_out = 0;
        int  bad   = 0;
        bit         v, c1, c2;
        logic [7:0] a, b, c;
        for (int i = 0; i < N + 8; i++) begin vexp[i] = 1'b0; dexp[i] = 8'd0; end
        do_reset();
        for (int cyc = 0; cyc < N + 4; cyc++) begin
            v  = (cyc < N) && ($urandom_range(3) != 0);
            c1 = 1'($urandom); c2 = 1'($urandom);
            a  = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            drive(v, c1, c2, a, b, c);
            #1;
            if (bus.out_valid !== vexp[cyc] || (vexp[cyc] && bus.out_data !== dexp[cyc])) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_cyc%0d got=%0b/%0d exp=%0b/%0d", cyc, bus.out_valid, bus.out_data, vexp[cyc], dexp[cyc]);
            end
            if (done_cnt !== 4'(exp_cnt % 16)) begin
                bad++;
                if (bad <= 5) $display("FAIL rand_cnt_cyc%0d got=%0d exp=%0d", cyc, done_cnt, exp_cnt % 16);
            end
            if (bus.in_ready !== 1'b1) begin
                bad++;
                if (bad <= 5) $display("FAIL rand_in_ready_cyc%0d got=%0b exp=1", cyc, bus.in_ready);
            end
            if (bus.out_valid) begin exp_cnt++; n_out++; end
            if (v) begin
                vexp[cyc + 3] = 1'b1;
                dexp[cyc + 3] = golden(c1, c2, int'(a), int'(b), int'(c));
                n_in++;
            end
            tick();
        end
        idle();
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL rand_stream got=%0d errors exp=0", bad); end
        checks++;
        if (n_out !== n_in || n_in <= 16) begin
            failures++;
            $display("FAIL rand_counts got=%0d results exp=%0d (>16)", n_out, n_in);
        end
        checks++;
        if (done_cnt !== 4'(n_in % 16)) begin failures++; $display("FAIL rand_wrap got=%0d exp=%0d", done_cnt, n_in % 16); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
